// File: rtl/agc_seq_pkg.sv
// rtl/agc_seq_pkg.sv - shared types and constants for the AGC loop sequencer
package agc_seq_pkg;

  localparam int SCALE_W  = 17;
  localparam int OFFSET_W = 16;
  localparam int SQ_W     = 24;
  localparam int CNT_W    = 21;

  // Register offsets inside one agc_wrapper window (adr[4:2])
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SQ     = 3'd1;
  localparam logic [2:0] REG_GT     = 3'd2;
  localparam logic [2:0] REG_LT     = 3'd3;
  localparam logic [2:0] REG_SCALE  = 3'd4;
  localparam logic [2:0] REG_OFFSET = 3'd5;

  // Control register command words and status bit
  localparam logic [31:0] CTRL_TICK     = 32'h0000_0001;
  localparam logic [31:0] CTRL_LOAD     = 32'h0000_0300;
  localparam logic [31:0] CTRL_APPLY    = 32'h0000_0400;
  localparam int          CTRL_DONE_BIT = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_TICK, S_POLL, S_RD_SQ, S_RD_GT, S_RD_LT, S_CALC,
    S_WR_SCALE, S_WR_OFF, S_WR_LOAD, S_WR_APPLY, S_DONE
  } state_t;

  // Bus address of register r in channel c
  function automatic logic [7:0] wb_addr(input logic [2:0] c, input logic [2:0] r);
    return {c, r, 2'b00};
  endfunction

endpackage

// File: rtl/agc_seq_wb_master.sv
// rtl/agc_seq_wb_master.sv - single-transaction Wishbone master with ack timeout
module agc_seq_wb_master #(
  parameter int WB_TIMEOUT = 255
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  adr,
  input  logic [31:0] dat,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [7:0]  m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i
);

  localparam int TW = $clog2(WB_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;

  assign m_stb_o = m_cyc_o;
  assign m_sel_o = 4'hF;

  // Launch on req, hold everything until ack or timeout; done/err are one-cycle
  // pulses and block a relaunch in that cycle so the caller can move on first.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_cyc_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      tmo_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (m_cyc_o) begin
        if (m_ack_i) begin
          m_cyc_o <= 1'b0;
          done    <= 1'b1;
          rdata   <= m_dat_i;
        end else if (tmo_cnt == TW'(WB_TIMEOUT - 1)) begin
          m_cyc_o <= 1'b0;
          err     <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else if (req && !done && !err) begin
        m_cyc_o <= 1'b1;
        m_we_o  <= we;
        m_adr_o <= adr;
        m_dat_o <= dat;
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/agc_loop_sequencer.sv
// rtl/agc_loop_sequencer.sv - autonomous Wishbone master closing the AGC loop over NCHAN wrappers
module agc_loop_sequencer
  import agc_seq_pkg::*;
#(
  parameter int                  NCHAN       = 8,
  parameter logic [SCALE_W-1:0]  SCALE_INIT  = 17'h04000,
  parameter logic [OFFSET_W-1:0] OFFSET_INIT = 16'h0000,
  parameter int                  WB_TIMEOUT  = 255
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start_i,
  input  logic                cont_i,
  input  logic [SQ_W-1:0]     target_sq_i,
  input  logic [SQ_W-1:0]     sq_db_i,
  input  logic [SCALE_W-1:0]  scale_step_i,
  input  logic [CNT_W-1:0]    off_db_i,
  input  logic [OFFSET_W-1:0] off_step_i,
  output logic                busy_o,
  output logic                round_done_o,
  output logic                err_o,
  output logic [2:0]          err_chan_o,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  output logic                m_we_o,
  output logic [7:0]          m_adr_o,
  output logic [3:0]          m_sel_o,
  output logic [31:0]         m_dat_o,
  input  logic                m_ack_i,
  input  logic [31:0]         m_dat_i
);

  state_t              state_q, state_d;
  logic [2:0]          chan;
  logic [SCALE_W-1:0]  scale_q [8];
  logic [OFFSET_W-1:0] off_q   [8];
  logic [SQ_W-1:0]     rd_sq;
  logic [CNT_W-1:0]    rd_gt, rd_lt;

  logic        wb_req, wb_we, wb_done, wb_err;
  logic [2:0]  wb_reg;
  logic [31:0] wb_wdata, wb_rdata;
  logic        last_chan;
  logic        unused_rdata;

  logic [SQ_W:0]       hi_sum;
  logic [SQ_W-1:0]     sq_hi, sq_lo;
  logic [SCALE_W:0]    sc_sum;
  logic [SCALE_W-1:0]  cur_scale, scale_nxt;
  logic [CNT_W:0]      gt_lim, lt_lim;
  logic [OFFSET_W+1:0] off_ext, off_wide;
  logic [OFFSET_W-1:0] cur_off, off_nxt;

  assign last_chan    = (chan == 3'(NCHAN - 1));
  assign busy_o       = (state_q != S_IDLE);
  assign unused_rdata = ^wb_rdata[31:25];

  agc_seq_wb_master #(.WB_TIMEOUT(WB_TIMEOUT)) u_wb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (wb_req),
    .we      (wb_we),
    .adr     (wb_addr(chan, wb_reg)),
    .dat     (wb_wdata),
    .done    (wb_done),
    .err     (wb_err),
    .rdata   (wb_rdata),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_adr_o (m_adr_o),
    .m_sel_o (m_sel_o),
    .m_dat_o (m_dat_o),
    .m_ack_i (m_ack_i),
    .m_dat_i (m_dat_i)
  );

  // Saturating scale servo against a deadband window and gt/lt offset balance
  always_comb begin
    cur_scale = scale_q[chan];
    cur_off   = off_q[chan];
    hi_sum    = {1'b0, target_sq_i} + {1'b0, sq_db_i};
    sq_hi     = hi_sum[SQ_W] ? '1 : hi_sum[SQ_W-1:0];
    sq_lo     = (target_sq_i >= sq_db_i) ? (target_sq_i - sq_db_i) : '0;
    sc_sum    = {1'b0, cur_scale} + {1'b0, scale_step_i};
    scale_nxt = cur_scale;
    if (rd_sq > sq_hi) begin
      scale_nxt = (cur_scale >= scale_step_i) ? (cur_scale - scale_step_i) : '0;
    end else if (rd_sq < sq_lo) begin
      scale_nxt = sc_sum[SCALE_W] ? '1 : sc_sum[SCALE_W-1:0];
    end
    gt_lim   = {1'b0, rd_lt} + {1'b0, off_db_i};
    lt_lim   = {1'b0, rd_gt} + {1'b0, off_db_i};
    off_ext  = {{2{cur_off[OFFSET_W-1]}}, cur_off};
    off_wide = off_ext;
    if ({1'b0, rd_gt} > gt_lim) begin
      off_wide = off_ext - {2'b00, off_step_i};
    end else if ({1'b0, rd_lt} > lt_lim) begin
      off_wide = off_ext + {2'b00, off_step_i};
    end
    if (off_wide[OFFSET_W+1:OFFSET_W-1] == 3'b000 || off_wide[OFFSET_W+1:OFFSET_W-1] == 3'b111) begin
      off_nxt = off_wide[OFFSET_W-1:0];
    end else begin
      off_nxt = off_wide[OFFSET_W+1] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Next-state and bus request for the current phase; a bus timeout aborts to IDLE
  always_comb begin
    state_d  = state_q;
    wb_req   = 1'b0;
    wb_we    = 1'b0;
    wb_reg   = REG_CTRL;
    wb_wdata = '0;
    case (state_q)
      S_IDLE:     if (start_i) state_d = S_TICK;
      S_TICK: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_wdata = CTRL_TICK;
        if (wb_done && last_chan) state_d = S_POLL;
      end
      S_POLL: begin
        wb_req = 1'b1;
        if (wb_done && wb_rdata[CTRL_DONE_BIT]) state_d = S_RD_SQ;
      end
      S_RD_SQ: begin
        wb_req = 1'b1; wb_reg = REG_SQ;
        if (wb_done) state_d = S_RD_GT;
      end
      S_RD_GT: begin
        wb_req = 1'b1; wb_reg = REG_GT;
        if (wb_done) state_d = S_RD_LT;
      end
      S_RD_LT: begin
        wb_req = 1'b1; wb_reg = REG_LT;
        if (wb_done) state_d = S_CALC;
      end
      S_CALC:     state_d = S_WR_SCALE;
      S_WR_SCALE: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_reg = REG_SCALE; wb_wdata = 32'(scale_q[chan]);
        if (wb_done) state_d = S_WR_OFF;
      end
      S_WR_OFF: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_reg = REG_OFFSET; wb_wdata = 32'(off_q[chan]);
        if (wb_done) state_d = S_WR_LOAD;
      end
      S_WR_LOAD: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_wdata = CTRL_LOAD;
        if (wb_done) state_d = S_WR_APPLY;
      end
      S_WR_APPLY: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_wdata = CTRL_APPLY;
        if (wb_done) state_d = last_chan ? S_DONE : S_POLL;
      end
      S_DONE:     state_d = cont_i ? S_TICK : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (wb_err) state_d = S_IDLE;
  end

  // State, channel walk, accumulator capture, per-channel register files and error flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      chan         <= '0;
      rd_sq        <= '0;
      rd_gt        <= '0;
      rd_lt        <= '0;
      round_done_o <= 1'b0;
      err_o        <= 1'b0;
      err_chan_o   <= '0;
      for (int i = 0; i < 8; i++) begin
        scale_q[i] <= SCALE_INIT;
        off_q[i]   <= OFFSET_INIT;
      end
    end else begin
      state_q      <= state_d;
      round_done_o <= (state_d == S_DONE);
      if (state_q == S_IDLE || state_q == S_DONE) begin
        chan <= '0;
      end else if (wb_done && (state_q == S_TICK || state_q == S_WR_APPLY)) begin
        chan <= last_chan ? 3'd0 : chan + 3'd1;
      end
      if (wb_done) begin
        case (state_q)
          S_RD_SQ: rd_sq <= wb_rdata[SQ_W:1];
          S_RD_GT: rd_gt <= wb_rdata[CNT_W-1:0];
          S_RD_LT: rd_lt <= wb_rdata[CNT_W-1:0];
          default: ;
        endcase
      end
      if (state_q == S_CALC) begin
        scale_q[chan] <= scale_nxt;
        off_q[chan]   <= off_nxt;
      end
      if (wb_err) begin
        err_o      <= 1'b1;
        err_chan_o <= chan;
      end else if (state_q == S_IDLE && start_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_agc_loop_sequencer.sv
// tb/tb_agc_loop_sequencer.sv - directed bench for agc_loop_sequencer with two wrapper BFMs
module tb_agc_loop_sequencer;

  typedef struct {
    logic [23:0] target;
    logic [23:0] db;
    logic [16:0] sstep;
    logic [20:0] odb;
    logic [15:0] ostep;
    logic [31:0] sq0, gt0, lt0, sq1, gt1, lt1;
    logic [16:0] esc0, esc1;
    logic [15:0] eof0, eof1;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start_i = 1'b0;
  logic        cont_i = 1'b0;
  logic [23:0] target_sq_i = '0;
  logic [23:0] sq_db_i = '0;
  logic [16:0] scale_step_i = '0;
  logic [20:0] off_db_i = '0;
  logic [15:0] off_step_i = '0;
  logic        busy_o, round_done_o, err_o;
  logic [2:0]  err_chan_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [7:0]  m_adr_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_o;
  logic        m_ack_i = 1'b0;
  logic [31:0] m_dat_i = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] sq_v [2];
  logic [31:0] gt_v [2];
  logic [31:0] lt_v [2];
  bit          stuck [2];
  int          polls [2];
  int          acnt = 0;
  int          bc, br;
  logic [7:0]  log_adr [64];
  logic [31:0] log_dat [64];
  int          nwr = 0;
  int          proto_err = 0;
  logic        prev_cyc = 1'b0;
  logic [40:0] prev_txn = '0;
  vec_t        vecs [6];

  always #5 aclk = ~aclk;

  agc_loop_sequencer #(.NCHAN(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .cont_i(cont_i),
    .target_sq_i(target_sq_i), .sq_db_i(sq_db_i), .scale_step_i(scale_step_i),
    .off_db_i(off_db_i), .off_step_i(off_step_i), .busy_o(busy_o),
    .round_done_o(round_done_o), .err_o(err_o), .err_chan_o(err_chan_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
  );

  // Wrapper BFM: ack in the third cycle of a strobe; CTRL reads report done from the second poll
  always @(negedge aclk) begin
    if (m_ack_i) begin
      m_ack_i = 1'b0;
      acnt = 0;
    end else if (m_cyc_o && m_stb_o) begin
      bc = int'(m_adr_o[7:5]);
      br = int'(m_adr_o[4:2]);
      if (bc < 2 && !stuck[bc]) begin
        acnt++;
        if (acnt == 3) begin
          acnt = 0;
          m_ack_i = 1'b1;
          if (m_we_o) begin
            if (nwr < 64) begin
              log_adr[nwr] = m_adr_o;
              log_dat[nwr] = m_dat_o;
            end
            nwr++;
            if (br == 0 && m_dat_o == 32'h1) polls[bc] = 0;
            m_dat_i = '0;
          end else begin
            case (br)
              0: begin polls[bc]++; m_dat_i = (polls[bc] >= 2) ? 32'h2 : 32'h0; end
              1: m_dat_i = sq_v[bc];
              2: m_dat_i = gt_v[bc];
              3: m_dat_i = lt_v[bc];
              default: m_dat_i = '0;
            endcase
          end
        end
      end
    end else begin
      acnt = 0;
    end
  end

  // Bus protocol watcher: stb tracks cyc, sel full, request stable while cyc stays high
  always @(negedge aclk) begin
    if (m_stb_o !== m_cyc_o) proto_err++;
    if (m_cyc_o && m_sel_o !== 4'hF) proto_err++;
    if (m_cyc_o && prev_cyc && {m_we_o, m_adr_o, m_dat_o} !== prev_txn) proto_err++;
    prev_cyc = m_cyc_o;
    prev_txn = {m_we_o, m_adr_o, m_dat_o};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [23:0] target, input logic [23:0] db, input logic [16:0] sstep,
                              input logic [20:0] odb, input logic [15:0] ostep,
                              input logic [31:0] sq0, input logic [31:0] gt0, input logic [31:0] lt0,
                              input logic [31:0] sq1, input logic [31:0] gt1, input logic [31:0] lt1,
                              input logic [16:0] esc0, input logic [15:0] eof0,
                              input logic [16:0] esc1, input logic [15:0] eof1);
    vec_t v;
    v.target = target; v.db = db; v.sstep = sstep; v.odb = odb; v.ostep = ostep;
    v.sq0 = sq0; v.gt0 = gt0; v.lt0 = lt0; v.sq1 = sq1; v.gt1 = gt1; v.lt1 = lt1;
    v.esc0 = esc0; v.eof0 = eof0; v.esc1 = esc1; v.eof1 = eof1;
    return v;
  endfunction

  task automatic apply_vec(input int k);
    target_sq_i = vecs[k].target; sq_db_i = vecs[k].db; scale_step_i = vecs[k].sstep;
    off_db_i = vecs[k].odb; off_step_i = vecs[k].ostep;
    sq_v[0] = vecs[k].sq0; gt_v[0] = vecs[k].gt0; lt_v[0] = vecs[k].lt0;
    sq_v[1] = vecs[k].sq1; gt_v[1] = vecs[k].gt1; lt_v[1] = vecs[k].lt1;
  endtask

  task automatic pulse_start();
    @(negedge aclk); start_i = 1'b1;
    @(negedge aclk); start_i = 1'b0;
  endtask

  task automatic run_round(input int k);
    int pulses;
    bit ended;
    logic [7:0]  ea [10];
    logic [31:0] ed [10];
    pulses = 0;
    ended = 1'b0;
    apply_vec(k);
    nwr = 0;
    pulse_start();
    check($sformatf("r%0d_busy", k), 64'(busy_o), 64'd1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      if (round_done_o) pulses++;
      if (!busy_o) begin ended = 1'b1; break; end
    end
    check($sformatf("r%0d_ended", k), 64'(ended), 64'd1);
    check($sformatf("r%0d_done_pulses", k), 64'(pulses), 64'd1);
    check($sformatf("r%0d_err", k), 64'(err_o), 64'd0);
    check($sformatf("r%0d_nwr", k), 64'(nwr), 64'd10);
    ea = '{8'h00, 8'h20, 8'h10, 8'h14, 8'h00, 8'h00, 8'h30, 8'h34, 8'h20, 8'h20};
    ed = '{32'h1, 32'h1, 32'(vecs[k].esc0), 32'(vecs[k].eof0), 32'h300, 32'h400,
           32'(vecs[k].esc1), 32'(vecs[k].eof1), 32'h300, 32'h400};
    for (int i = 0; i < 10; i++) begin
      check($sformatf("r%0d_wr%0d", k, i), {24'h0, log_adr[i], log_dat[i]}, {24'h0, ea[i], ed[i]});
    end
  endtask

  initial begin
    int pulses;
    int cyc_run;
    bit ended;
    bit restarted;

    // Per-round stimulus and expected scale/offset after CALC for both channels
    vecs[0] = mk(24'h100, 24'h10, 17'h100,   21'd50, 16'h10,   32'h400, 100, 100, 32'h200, 500, 100,
                 17'h03F00, 16'h0000, 17'h04000, 16'hFFF0);
    vecs[1] = mk(24'h100, 24'h10, 17'h3E80,  21'd50, 16'h7FF8, 32'h400, 100, 500, 32'h200, 100, 100,
                 17'h00080, 16'h7FF8, 17'h04000, 16'hFFF0);
    vecs[2] = mk(24'h100, 24'h10, 17'h100,   21'd50, 16'h10,   32'h400, 100, 500, 32'h000, 500, 100,
                 17'h00000, 16'h7FFF, 17'h04100, 16'hFFE0);
    vecs[3] = mk(24'h100, 24'h10, 17'h1FFFF, 21'd50, 16'h7FFF, 32'h200, 100, 100, 32'h000, 500, 100,
                 17'h00000, 16'h7FFF, 17'h1FFFF, 16'h8000);
    vecs[4] = mk(24'h100, 24'h10, 17'h100,   21'd50, 16'h10,   32'h220, 150, 100, 32'h1E0, 100, 150,
                 17'h00000, 16'h7FFF, 17'h1FFFF, 16'h8000);
    vecs[5] = mk(24'h100, 24'h10, 17'h100,   21'd50, 16'h10,   32'h200, 100, 100, 32'h200, 100, 100,
                 17'h04000, 16'h0000, 17'h04000, 16'h0000);
    stuck[0] = 1'b0; stuck[1] = 1'b0;
    polls[0] = 0; polls[1] = 0;

    repeat (3) @(negedge aclk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_cyc_stb_we", {61'd0, m_cyc_o, m_stb_o, m_we_o}, 64'd0);
    check("rst_done_err", {61'd0, round_done_o, err_o, 1'b0}, 64'd0);
    check("rst_err_chan", 64'(err_chan_o), 64'd0);
    aresetn = 1'b1;

    for (int k = 0; k < 5; k++) run_round(k);

    // Channel 1 never acks: abort after the timeout, no done pulse, cont_i does not restart
    apply_vec(5);
    stuck[1] = 1'b1;
    cont_i = 1'b1;
    pulse_start();
    pulses = 0; cyc_run = 0; ended = 1'b0; restarted = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (m_cyc_o && m_adr_o[7:5] == 3'd1) cyc_run++;
      if (round_done_o) pulses++;
      if (!busy_o) begin ended = 1'b1; break; end
    end
    check("tmo_ended", 64'(ended), 64'd1);
    check("tmo_cyc_len", 64'(cyc_run), 64'd255);
    check("tmo_err", 64'(err_o), 64'd1);
    check("tmo_err_chan", 64'(err_chan_o), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (busy_o || round_done_o) restarted = 1'b1;
    end
    check("tmo_no_restart", 64'(restarted | (pulses != 0)), 64'd0);
    stuck[1] = 1'b0;

    // start_i clears the sticky error; cont_i chains a second round without a new start
    pulse_start();
    check("err_cleared", 64'(err_o), 64'd0);
    pulses = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge aclk);
      if (round_done_o) pulses++;
      if (pulses == 1 && !round_done_o) cont_i = 1'b0;
      if (!busy_o) break;
    end
    cont_i = 1'b0;
    check("cont_rounds", 64'(pulses), 64'd2);

    // Reset during POLL drops cyc at the next edge and restores the register files
    nwr = 0;
    pulse_start();
    ended = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge aclk);
      if (m_cyc_o && !m_we_o && m_adr_o == 8'h00) begin ended = 1'b1; break; end
    end
    check("poll_reached", 64'(ended), 64'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_rst_cyc", 64'(m_cyc_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    aresetn = 1'b1;
    run_round(5);

    check("wb_protocol", 64'(proto_err), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
